// File: rtl/gigabit_ingress_fifo_reader_if.sv
// FIFO-read and AXI-stream signal bundle between the ingress FIFO reader and its neighbours.
interface gigabit_ingress_fifo_reader_if #(
    parameter int unsigned ADDR_BITS = 12
);
    logic [ADDR_BITS:0]   wr_ptr_committed;
    logic [ADDR_BITS:0]   rd_ptr;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [71:0]          rd_data;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [63:0]          m_tdata;
    logic [7:0]           m_tkeep;
    logic                 m_tlast;
    logic [11:0]          m_tdest;

    // Reader side
    modport master (
        input  wr_ptr_committed, rd_data, m_tready,
        output rd_ptr, rd_en, rd_addr, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest
    );

    // Writer / URAM / stream-sink side
    modport slave (
        output wr_ptr_committed, rd_data, m_tready,
        input  rd_ptr, rd_en, rd_addr, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest
    );
endinterface

// File: rtl/gigabit_ingress_fifo_reader.sv
// Read-side controller of the per-port URAM ingress FIFO: fetches each frame header,
// streams the body as 64-bit AXI-stream and frees space back to the writer.
module gigabit_ingress_fifo_reader #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    gigabit_ingress_fifo_reader_if.master bus
);
    localparam int unsigned ADDR_BITS = $clog2(DEPTH);
    localparam int unsigned PTR_W     = ADDR_BITS + 1;
    localparam int unsigned SKID_Q    = 3;   // queue behind the output register: 4 beats total

    typedef enum logic [1:0] {IDLE, HDR_WAIT, BODY, RELEASE} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        fptr_q, fptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0]    rd_addr_q, rd_addr_d;
    logic [8:0]              issue_left_q, issue_left_d;
    logic [8:0]              ret_left_q, ret_left_d;
    logic [2:0]              outst_q, outst_d;
    logic [2:0]              len_lo_q, len_lo_d;
    logic [11:0]             vlan_q, vlan_d;
    logic [RD_LATENCY-1:0]   pipe_q;

    beat_t                   out_q;
    logic                    out_vld_q;
    beat_t                   q_mem [0:SKID_Q-1];
    logic [1:0]              q_cnt_q;

    logic                    ret_vld;
    logic                    pop;
    logic                    push;
    logic [2:0]              occ;
    logic                    credit_ok;
    logic [10:0]             hdr_len;
    logic [8:0]              hdr_words;
    logic [7:0]              last_keep;
    beat_t                   push_beat;
    logic                    rd_data_unused;

    assign rd_data_unused = ^bus.rd_data[71:64];

    // Datapath helpers: return strobe, handshake, credit and the beat built from returning data
    assign ret_vld   = pipe_q[RD_LATENCY-1];
    assign pop       = out_vld_q && bus.m_tready;
    assign push      = ret_vld && (state_q == BODY);
    assign occ       = 3'(out_vld_q) + 3'(q_cnt_q);
    assign credit_ok = (4'(outst_q) + 4'(occ)) < (4'd4 + 4'(pop));
    assign hdr_len   = bus.rd_data[10:0];
    assign hdr_words = 9'((12'(hdr_len) + 12'd7) >> 3);
    assign last_keep = (len_lo_q == 3'd0) ? 8'hFF : 8'((8'h01 << len_lo_q) - 8'h01);

    // Shape the beat pushed into the skid queue
    always_comb begin
        push_beat      = '0;
        push_beat.data = bus.rd_data[63:0];
        push_beat.last = (ret_left_q == 9'd1);
        push_beat.keep = push_beat.last ? last_keep : 8'hFF;
    end

    // Next-state and control outputs of the read FSM
    always_comb begin
        state_d      = state_q;
        fptr_d       = fptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        issue_left_d = issue_left_q;
        ret_left_d   = ret_left_q;
        outst_d      = outst_q;
        len_lo_d     = len_lo_q;
        vlan_d       = vlan_q;

        if (push) begin
            ret_left_d = ret_left_q - 9'd1;
            outst_d    = outst_q - 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (fptr_q != bus.wr_ptr_committed) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = fptr_q[ADDR_BITS-1:0];
                    fptr_d    = fptr_q + PTR_W'(1);
                    state_d   = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (ret_vld) begin
                    len_lo_d = hdr_len[2:0];
                    vlan_d   = bus.rd_data[27:16];
                    if (hdr_len == 11'd0) begin
                        state_d = RELEASE;
                    end else begin
                        // first body read goes out in the same cycle the header lands
                        rd_en_d      = 1'b1;
                        rd_addr_d    = fptr_q[ADDR_BITS-1:0];
                        fptr_d       = fptr_q + PTR_W'(1);
                        issue_left_d = hdr_words - 9'd1;
                        ret_left_d   = hdr_words;
                        outst_d      = 3'd1;
                        state_d      = BODY;
                    end
                end
            end
            BODY: begin
                if ((issue_left_q != 9'd0) && credit_ok) begin
                    rd_en_d      = 1'b1;
                    rd_addr_d    = fptr_q[ADDR_BITS-1:0];
                    fptr_d       = fptr_q + PTR_W'(1);
                    issue_left_d = issue_left_q - 9'd1;
                    outst_d      = outst_d + 3'd1;
                end
                if (pop && out_q.last) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                rd_ptr_d = fptr_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and control register bank
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            fptr_q       <= '0;
            rd_ptr_q     <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            issue_left_q <= '0;
            ret_left_q   <= '0;
            outst_q      <= '0;
            len_lo_q     <= '0;
            vlan_q       <= '0;
            pipe_q       <= '0;
        end else begin
            state_q      <= state_d;
            fptr_q       <= fptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            issue_left_q <= issue_left_d;
            ret_left_q   <= ret_left_d;
            outst_q      <= outst_d;
            len_lo_q     <= len_lo_d;
            vlan_q       <= vlan_d;
            pipe_q       <= (pipe_q << 1) | RD_LATENCY'(rd_en_q);
        end
    end

    // Skid buffer: registered output beat backed by a small shift queue
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            q_cnt_q   <= '0;
            for (int i = 0; i < SKID_Q; i++) begin
                q_mem[i] <= '0;
            end
        end else if (!out_vld_q || pop) begin
            if (q_cnt_q != 2'd0) begin
                out_q     <= q_mem[0];
                out_vld_q <= 1'b1;
                q_mem[0]  <= q_mem[1];
                q_mem[1]  <= q_mem[2];
                if (push) begin
                    q_mem[q_cnt_q - 2'd1] <= push_beat;
                end
                q_cnt_q <= q_cnt_q - 2'd1 + 2'(push);
            end else begin
                out_vld_q <= push;
                if (push) begin
                    out_q <= push_beat;
                end
            end
        end else if (push) begin
            q_mem[q_cnt_q] <= push_beat;
            q_cnt_q        <= q_cnt_q + 2'd1;
        end
    end

    assign bus.rd_ptr   = rd_ptr_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.m_tvalid = out_vld_q;
    assign bus.m_tdata  = out_q.data;
    assign bus.m_tkeep  = out_q.keep;
    assign bus.m_tlast  = out_q.last;
    assign bus.m_tdest  = vlan_q;
endmodule
